// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with stall hold, bubble/flush NOP insertion and valid gating.
// Optional PIPE_STATS_EN macro adds bubble and stall event counters.
module id_ex_pipeline_reg #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            bubble_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic [4:0]      id_rd_addr_i,
    input  logic [2:0]      id_alu_op_i,
    input  logic [2:0]      id_funct3_i,
    input  logic            id_funct7_i,
    input  logic            id_alu_src_b_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic [1:0]      id_wb_sel_i,
    input  logic            id_branch_i,
    input  logic            id_jump_i,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [4:0]      ex_rd_addr,
    output logic [2:0]      ex_alu_op,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7,
    output logic            ex_alu_src_b,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [1:0]      ex_wb_sel,
    output logic            ex_branch,
    output logic            ex_jump
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]     stat_bubble_cnt_o,
    output logic [31:0]     stat_stall_cnt_o
`endif
);

    // alu_op_e encoding: RTYPE=0, ITYPE_ARITH=1, LOAD_STORE=2, BRANCH=3, LUI=4, AUIPC=5, JUMP=6
    localparam logic [2:0] ALUOP_ITYPE_ARITH = 3'd1;

    logic            w_kill;
    logic            w_load;
    logic            w_live;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd_addr;
    logic [2:0]      r_alu_op;
    logic [2:0]      r_funct3;
    logic            r_funct7;
    logic            r_alu_src_b;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic [1:0]      r_wb_sel;
    logic            r_branch;
    logic            r_jump;

    // Flush and bubble both override a stall; side-effect bits survive only for a live slot.
    assign w_kill = flush_i | bubble_i;
    assign w_load = w_kill | ~stall_i;
    assign w_live = ~w_kill & id_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_alu_op    <= ALUOP_ITYPE_ARITH;
            r_funct3    <= '0;
            r_funct7    <= 1'b0;
            r_alu_src_b <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_sel    <= '0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
        end else if (w_load) begin
            r_valid     <= w_live;
            r_pc        <= w_kill ? '0 : id_pc_i;
            r_rs1_data  <= w_kill ? '0 : id_rs1_data_i;
            r_rs2_data  <= w_kill ? '0 : id_rs2_data_i;
            r_imm       <= w_kill ? '0 : id_imm_i;
            r_rs1_addr  <= w_kill ? '0 : id_rs1_addr_i;
            r_rs2_addr  <= w_kill ? '0 : id_rs2_addr_i;
            r_rd_addr   <= w_kill ? '0 : id_rd_addr_i;
            r_alu_op    <= w_kill ? ALUOP_ITYPE_ARITH : id_alu_op_i;
            r_funct3    <= w_kill ? '0 : id_funct3_i;
            r_funct7    <= ~w_kill & id_funct7_i;
            r_alu_src_b <= ~w_kill & id_alu_src_b_i;
            r_reg_write <= w_live & id_reg_write_i;
            r_mem_read  <= w_live & id_mem_read_i;
            r_mem_write <= w_live & id_mem_write_i;
            r_wb_sel    <= w_kill ? '0 : id_wb_sel_i;
            r_branch    <= w_live & id_branch_i;
            r_jump      <= w_live & id_jump_i;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_rs1_addr  = r_rs1_addr;
    assign ex_rs2_addr  = r_rs2_addr;
    assign ex_rd_addr   = r_rd_addr;
    assign ex_alu_op    = r_alu_op;
    assign ex_funct3    = r_funct3;
    assign ex_funct7    = r_funct7;
    assign ex_alu_src_b = r_alu_src_b;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;
    assign ex_wb_sel    = r_wb_sel;
    assign ex_branch    = r_branch;
    assign ex_jump      = r_jump;

`ifdef PIPE_STATS_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_kill) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (!w_load) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stat_bubble_cnt_o = r_bubble_cnt;
    assign stat_stall_cnt_o  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed hazard scenarios plus randomized
// stimulus compared against a slot-level reference model.
module tb_id_ex_pipeline_reg;

    localparam logic [2:0] ALUOP_RTYPE       = 3'd0;
    localparam logic [2:0] ALUOP_ITYPE_ARITH = 3'd1;
    localparam logic [2:0] ALUOP_LOAD_STORE  = 3'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
        logic [2:0]  alu_op;
        logic [2:0]  f3;
        logic        f7;
        logic        src_b;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  wb;
        logic        br;
        logic        jp;
    } slot_t;

    logic  clk;
    logic  rst_n;
    logic  stall_i;
    logic  bubble_i;
    logic  flush_i;
    slot_t stim;
    slot_t obs;
    slot_t exp_slot;
    slot_t saved;
    int    n_checks;
    int    n_fails;
`ifdef PIPE_STATS_EN
    logic [31:0] stat_bubble_cnt_o;
    logic [31:0] stat_stall_cnt_o;
    logic [31:0] exp_bc;
    logic [31:0] exp_sc;
`endif

    logic            ex_valid, ex_funct7, ex_alu_src_b, ex_reg_write, ex_mem_read;
    logic            ex_mem_write, ex_branch, ex_jump;
    logic [31:0]     ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [2:0]      ex_alu_op, ex_funct3;
    logic [1:0]      ex_wb_sel;

    id_ex_pipeline_reg #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .bubble_i       (bubble_i),
        .flush_i        (flush_i),
        .id_valid_i     (stim.valid),
        .id_pc_i        (stim.pc),
        .id_rs1_data_i  (stim.rs1),
        .id_rs2_data_i  (stim.rs2),
        .id_imm_i       (stim.imm),
        .id_rs1_addr_i  (stim.rs1a),
        .id_rs2_addr_i  (stim.rs2a),
        .id_rd_addr_i   (stim.rda),
        .id_alu_op_i    (stim.alu_op),
        .id_funct3_i    (stim.f3),
        .id_funct7_i    (stim.f7),
        .id_alu_src_b_i (stim.src_b),
        .id_reg_write_i (stim.rw),
        .id_mem_read_i  (stim.mr),
        .id_mem_write_i (stim.mw),
        .id_wb_sel_i    (stim.wb),
        .id_branch_i    (stim.br),
        .id_jump_i      (stim.jp),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rs1_addr    (ex_rs1_addr),
        .ex_rs2_addr    (ex_rs2_addr),
        .ex_rd_addr     (ex_rd_addr),
        .ex_alu_op      (ex_alu_op),
        .ex_funct3      (ex_funct3),
        .ex_funct7      (ex_funct7),
        .ex_alu_src_b   (ex_alu_src_b),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_wb_sel      (ex_wb_sel),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump)
`ifdef PIPE_STATS_EN
        ,
        .stat_bubble_cnt_o (stat_bubble_cnt_o),
        .stat_stall_cnt_o  (stat_stall_cnt_o)
`endif
    );

    assign obs = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr,
                  ex_rd_addr, ex_alu_op, ex_funct3, ex_funct7, ex_alu_src_b, ex_reg_write,
                  ex_mem_read, ex_mem_write, ex_wb_sel, ex_branch, ex_jump};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // addi x0,x0,0 as seen by EX
    function automatic slot_t nop_slot();
        slot_t s;
        s        = '0;
        s.alu_op = ALUOP_ITYPE_ARITH;
        return s;
    endfunction

    function automatic slot_t model_next(slot_t cur, slot_t in, logic st, logic bb, logic fl);
        slot_t n;
        if (fl || bb) return nop_slot();
        if (st) return cur;
        n = in;
        if (!in.valid) begin
            n.rw = 1'b0;
            n.mr = 1'b0;
            n.mw = 1'b0;
            n.br = 1'b0;
            n.jp = 1'b0;
        end
        return n;
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        s.valid  = ($urandom_range(0, 3) != 0);
        s.pc     = $urandom;
        s.rs1    = $urandom;
        s.rs2    = $urandom;
        s.imm    = $urandom;
        s.rs1a   = 5'($urandom);
        s.rs2a   = 5'($urandom);
        s.rda    = 5'($urandom);
        s.alu_op = 3'($urandom_range(0, 6));
        s.f3     = 3'($urandom);
        s.f7     = 1'($urandom);
        s.src_b  = 1'($urandom);
        s.rw     = 1'($urandom);
        s.mr     = 1'($urandom);
        s.mw     = 1'($urandom);
        s.wb     = 2'($urandom_range(0, 2));
        s.br     = 1'($urandom);
        s.jp     = 1'($urandom);
        return s;
    endfunction

    task automatic step(input logic st, input logic bb, input logic fl, input string tag);
        stall_i  = st;
        bubble_i = bb;
        flush_i  = fl;
        @(posedge clk);
        exp_slot = model_next(exp_slot, stim, st, bb, fl);
`ifdef PIPE_STATS_EN
        if (fl || bb) exp_bc = exp_bc + 32'd1;
        else if (st) exp_sc = exp_sc + 32'd1;
`endif
        #1;
        check_eq(tag, obs, exp_slot);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        exp_slot = nop_slot();
`ifdef PIPE_STATS_EN
        exp_bc = '0;
        exp_sc = '0;
`endif
        #1;
        check_eq("reset_async", obs, nop_slot());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        stall_i  = 1'b0;
        bubble_i = 1'b0;
        flush_i  = 1'b0;
        stim     = '0;
        exp_slot = nop_slot();
`ifdef PIPE_STATS_EN
        exp_bc = '0;
        exp_sc = '0;
`endif
        #12;
        check_eq("reset_state", obs, nop_slot());
        check_eq("reset_alu_op", 160'(ex_alu_op), 160'(ALUOP_ITYPE_ARITH));
        rst_n = 1'b1;

        // add x3,x1,x2
        stim        = '0;
        stim.valid  = 1'b1;
        stim.pc     = 32'h100;
        stim.rs1    = 32'd5;
        stim.rs2    = 32'd7;
        stim.rs1a   = 5'd1;
        stim.rs2a   = 5'd2;
        stim.rda    = 5'd3;
        stim.alu_op = ALUOP_RTYPE;
        stim.rw     = 1'b1;
        step(1'b0, 1'b0, 1'b0, "add_capture");
        check_eq("add_valid", 160'(ex_valid), 160'(1'b1));
        check_eq("add_rd", 160'(ex_rd_addr), 160'(5'd3));
        check_eq("add_pc", 160'(ex_pc), 160'(32'h100));

        saved = exp_slot;
        for (int i = 0; i < 3; i++) begin
            stim = rand_slot();
            step(1'b1, 1'b0, 1'b0, "stall_hold");
            check_eq("stall_frozen", obs, saved);
        end
        stim       = rand_slot();
        stim.valid = 1'b1;
        step(1'b0, 1'b0, 1'b0, "stall_release");
        check_eq("stall_release_id", obs, stim);

        // lw x5,0(x1) then dependent add: bubble beats stall, ID held upstream
        stim        = '0;
        stim.valid  = 1'b1;
        stim.rda    = 5'd5;
        stim.alu_op = ALUOP_LOAD_STORE;
        stim.mr     = 1'b1;
        stim.rw     = 1'b1;
        stim.wb     = 2'b01;
        stim.src_b  = 1'b1;
        step(1'b0, 1'b0, 1'b0, "lw_capture");
        stim        = rand_slot();
        stim.valid  = 1'b1;
        stim.rs1a   = 5'd5;
        step(1'b1, 1'b1, 1'b0, "bubble_stall");
        check_eq("bubble_valid", 160'(ex_valid), 160'(1'b0));
        check_eq("bubble_mem_read", 160'(ex_mem_read), 160'(1'b0));
        step(1'b0, 1'b0, 1'b0, "bubble_release");
        check_eq("bubble_release_id", obs, stim);

        stim       = rand_slot();
        stim.valid = 1'b1;
        step(1'b1, 1'b1, 1'b1, "flush_all");
        check_eq("flush_valid", 160'(ex_valid), 160'(1'b0));

        stim       = rand_slot();
        stim.valid = 1'b0;
        stim.mw    = 1'b1;
        step(1'b0, 1'b0, 1'b0, "invalid_slot");
        check_eq("invalid_mem_write", 160'(ex_mem_write), 160'(1'b0));
        check_eq("invalid_pc_kept", 160'(ex_pc), 160'(stim.pc));

        // rd=0 writes pass through untouched
        stim       = rand_slot();
        stim.valid = 1'b1;
        stim.rw    = 1'b1;
        stim.rda   = 5'd0;
        step(1'b0, 1'b0, 1'b0, "rd0_write");
        check_eq("rd0_reg_write", 160'(ex_reg_write), 160'(1'b1));

        // Asynchronous reset mid-stall with reg_write live in EX
        stall_i = 1'b1;
        do_reset();
        check_eq("reset_reg_write", 160'(ex_reg_write), 160'(1'b0));
        stim       = rand_slot();
        stim.valid = 1'b1;
        step(1'b1, 1'b0, 1'b0, "post_reset_stall");
        step(1'b0, 1'b0, 1'b0, "post_reset_capture");

        for (int i = 0; i < 400; i++) begin
            stim = rand_slot();
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), "random");
        end

`ifdef PIPE_STATS_EN
        check_eq("stat_bubble_rand", 160'(stat_bubble_cnt_o), 160'(exp_bc));
        check_eq("stat_stall_rand", 160'(stat_stall_cnt_o), 160'(exp_sc));
        stall_i = 1'b0;
        do_reset();
        step(1'b0, 1'b0, 1'b1, "stat_flush0");
        step(1'b1, 1'b0, 1'b1, "stat_flush1");
        step(1'b0, 1'b1, 1'b0, "stat_bubble");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "stat_stall");
        check_eq("stat_bubble_cnt", 160'(stat_bubble_cnt_o), 160'(32'd3));
        check_eq("stat_stall_cnt", 160'(stat_stall_cnt_o), 160'(32'd4));
        force dut.r_bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_bubble_cnt;
        step(1'b0, 1'b1, 1'b0, "stat_wrap_edge");
        check_eq("stat_bubble_wrap", 160'(stat_bubble_cnt_o), 160'(32'd0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
